// File: rtl/morse_keyer.sv
// ============================================================================
// Module      : morse_keyer
// Description : Turns one (code, length) character per handshake into a timed
//               on/off key signal at standard Morse ratios (dot 1, dash 3,
//               element gap 1, character gap 3, word gap 7 units). Emits a
//               one-cycle done pulse when a character's trailing gap ends.
//               Optional build macro MORSE_FARNSWORTH_EN stretches the
//               character and word gaps by GAP_MULT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_keyer #(
    parameter int UNIT_CYCLES = 4_800_000,
    parameter int CODE_W      = 8,
    parameter int LEN_W       = 4,
    parameter int GAP_MULT    = 2
) (
    input  logic              clk,
    input  logic              rst,      // asynchronous, active low
    input  logic [CODE_W-1:0] i_code,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_key,
    output logic              o_busy,
    output logic              o_done
);

    localparam int c_presc_w = $clog2(UNIT_CYCLES);

`ifdef MORSE_FARNSWORTH_EN
    localparam int c_ucnt_w     = ($clog2(4 * GAP_MULT + 1) > 3) ? $clog2(4 * GAP_MULT + 1) : 3;
    localparam int c_char_units = 2 * GAP_MULT;
    localparam int c_word_units = 4 * GAP_MULT;
`else
    localparam int c_ucnt_w     = 3;
    localparam int c_char_units = 2;
    localparam int c_word_units = 4;
`endif

    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(UNIT_CYCLES - 1);
    localparam logic [c_ucnt_w-1:0]  c_dot_m1    = c_ucnt_w'(0);
    localparam logic [c_ucnt_w-1:0]  c_dash_m1   = c_ucnt_w'(2);
    localparam logic [c_ucnt_w-1:0]  c_gap_m1    = c_ucnt_w'(0);
    localparam logic [c_ucnt_w-1:0]  c_char_m1   = c_ucnt_w'(c_char_units - 1);
    localparam logic [c_ucnt_w-1:0]  c_word_m1   = c_ucnt_w'(c_word_units - 1);
    localparam logic [LEN_W-1:0]     c_max_len   = LEN_W'(CODE_W);

    // Refuse to elaborate with a prescaler too short or a non-positive stretch.
    if (UNIT_CYCLES < 2 || GAP_MULT < 1) begin : g_param_check
        $error("morse_keyer: UNIT_CYCLES must be >= 2 and GAP_MULT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_GAP  = 3'd2,
        S_CHAR = 3'd3,
        S_WORD = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_presc_w-1:0]  r_presc;
    logic [c_ucnt_w-1:0]   r_units;
    logic [LEN_W-1:0]      r_idx;
    logic [CODE_W-1:0]     r_code;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_dash;
    logic [LEN_W-1:0]      w_len;
    logic [c_ucnt_w-1:0]   w_dur_m1;

    assign o_ready  = (r_state == S_IDLE);
    assign o_busy   = !o_ready;
    assign o_key    = (r_state == S_ON);   // follows the async-reset state register
    assign o_done   = r_done;

    assign w_accept = i_valid && o_ready;
    assign w_len    = (i_len > c_max_len) ? c_max_len : i_len;
    assign w_tick   = (r_presc == c_presc_max);
    assign w_dash   = |(r_code & (CODE_W'(1) << r_idx));
    assign w_last   = w_tick && (r_units == w_dur_m1);

    // Phase length (in units, minus one) for the current state.
    always_comb begin
        w_dur_m1 = '0;
        case (r_state)
            S_ON:    w_dur_m1 = w_dash ? c_dash_m1 : c_dot_m1;
            S_GAP:   w_dur_m1 = c_gap_m1;
            S_CHAR:  w_dur_m1 = c_char_m1;
            S_WORD:  w_dur_m1 = c_word_m1;
            default: w_dur_m1 = '0;
        endcase
    end

    // Next-state selection; phases advance only on the last tick of their span.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (w_len == '0) ? S_WORD : S_ON;
            S_ON:   if (w_last) w_next = S_GAP;
            S_GAP:  if (w_last) w_next = (r_idx == '0) ? S_CHAR : S_ON;
            S_CHAR: if (w_last) w_next = S_IDLE;
            S_WORD: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Prescaler, unit counter, element index, captured code and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_units <= '0;
            r_idx   <= '0;
            r_code  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= ((r_state == S_CHAR) || (r_state == S_WORD)) && w_last;

            if (r_state == S_IDLE || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + c_presc_w'(1);
            end

            if (r_state == S_IDLE || w_last) begin
                r_units <= '0;
            end else if (w_tick) begin
                r_units <= r_units + c_ucnt_w'(1);
            end

            // Index is tested for zero before any decrement, so it never wraps.
            if (w_accept) begin
                r_code <= i_code;
                r_idx  <= (w_len == '0) ? '0 : (w_len - LEN_W'(1));
            end else if (r_state == S_GAP && w_last && r_idx != '0) begin
                r_idx <= r_idx - LEN_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morse_keyer.sv
// ============================================================================
// Module      : tb_morse_keyer
// Description : Self-checking bench for morse_keyer. Expected key waveforms
//               are built from the Morse timing ratios and compared cycle by
//               cycle against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_keyer;

    localparam int U = 4;
`ifdef MORSE_FARNSWORTH_EN
    localparam int G = 2;
`else
    localparam int G = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_code;
    logic [3:0] i_len;
    logic       i_valid;
    wire        o_ready;
    wire        o_key;
    wire        o_busy;
    wire        o_done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    morse_keyer #(
        .UNIT_CYCLES(U),
        .CODE_W     (8),
        .LEN_W      (4),
        .GAP_MULT   (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_code (i_code),
        .i_len  (i_len),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_key  (o_key),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    // Expected key level for every busy cycle of one character.
    task automatic build_expect(input logic [7:0] code, input int len);
        int eff;
        exp_q.delete();
        eff = (len > 8) ? 8 : len;
        if (eff == 0) begin
            repeat (4 * G * U) exp_q.push_back(1'b0);
        end else begin
            for (int e = eff - 1; e >= 0; e--) begin
                logic [7:0] sh;
                int         n;
                sh = code >> e;
                n  = sh[0] ? 3 : 1;
                repeat (n * U) exp_q.push_back(1'b1);
                repeat (U) exp_q.push_back(1'b0);
            end
            repeat (2 * G * U) exp_q.push_back(1'b0);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the done-pulse negedge.
    task automatic run_char(input logic [7:0] code, input logic [3:0] len, input string name,
                            input bit hold, input bit swap,
                            input logic [7:0] ncode, input logic [3:0] nlen);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        build_expect(code, int'(len));
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", name, o_ready);
        end
        i_code  = code;
        i_len   = len;
        i_valid = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0 && !hold) i_valid = 1'b0;
            if (i == 1 && swap) begin
                i_code = ncode;
                i_len  = nlen;
            end
            if (o_key !== exp_q[i] || o_busy !== 1'b1 || o_ready !== 1'b0 || o_done !== 1'b0) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s key_pattern got %0d bad cycles (first at %0d) want 0 of %0d",
                     name, bad, first, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_key !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse got done=%b ready=%b busy=%b key=%b want 1 1 0 0",
                     name, o_done, o_ready, o_busy, o_key);
        end
    endtask

    // One cycle after the done pulse: pulse gone, still idle.
    task automatic idle_check(input string name);
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_ready !== 1'b1 || o_key !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after_done got done=%b ready=%b key=%b want 0 1 0",
                     name, o_done, o_ready, o_key);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        i_valid = 1'b0;
        i_code  = '0;
        i_len   = '0;
        #1;
        checks++;
        if (o_key !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got key=%b busy=%b done=%b ready=%b want 0 0 0 1",
                     o_key, o_busy, o_done, o_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b done=%b want 1 0 0",
                     o_ready, o_busy, o_done);
        end
    endtask

    task automatic test_directed();
        run_char(8'h00, 4'd1, "E", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("E");
        run_char(8'b01, 4'd2, "A", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("A");
        run_char(8'h00, 4'd0, "space", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("space");
    endtask

    task automatic test_reset_mid_dash();
        int done_seen;
        done_seen = 0;
        i_code  = 8'h01;
        i_len   = 4'd1;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (o_key !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre key got %b want 1", o_key);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (o_key !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got key=%b ready=%b busy=%b want 0 1 0",
                     o_key, o_ready, o_busy);
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            if (o_done !== 1'b0 || o_key !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d active cycles want 0", done_seen);
        end
        run_char(8'h00, 4'd1, "E_after_reset", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("E_after_reset");
    endtask

    task automatic test_back_to_back();
        // 'E' with valid held; inputs switch to 'T' mid-character.
        run_char(8'h00, 4'd1, "b2b_E", 1'b1, 1'b1, 8'h01, 4'd1);
        run_char(8'h01, 4'd1, "b2b_T", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("b2b_T");
    endtask

    task automatic test_clamp();
        logic [7:0] c;
        c = 8'($urandom);
        run_char(c, 4'd9, "clamp9", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("clamp9");
        run_char(c, 4'd15, "clamp15", 1'b0, 1'b0, 8'h00, 4'd0);
        idle_check("clamp15");
    endtask

    task automatic test_random();
        logic [7:0] c;
        logic [3:0] l;
        for (int k = 0; k < 10; k++) begin
            c = 8'($urandom);
            l = 4'($urandom_range(0, 9));
            run_char(c, l, "random", 1'b0, 1'b0, 8'h00, 4'd0);
            idle_check("random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_dash();
        test_back_to_back();
        test_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Downstream of the ASCII-to-Morse convertor. Takes one character code and length per handshake and produces a timed on/off key signal at standard Morse ratios.
- Timing ratios: dot 1 unit, dash 3 units, element gap 1 unit, character gap 3 units, word gap 7 units.
- Replaces the ad-hoc delay/index logic in the top-level LED loop. Drives the LEDs and emits a per-character done pulse for the UART echo path.

Parameters:
- UNIT_CYCLES, 4_800_000, clock cycles per Morse unit (200 ms at 24 MHz); must be >= 2.
- CODE_W, 8, width of code input (maximum elements per character).
- LEN_W, 4, width of length input.
- GAP_MULT, 2, gap stretch factor; used only when MORSE_FARNSWORTH_EN is defined.

Ports:
- clk  in  1  system clock, 24 MHz.
- rst  in  1  asynchronous active-low reset.
- i_code  in  CODE_W  element pattern, MSB-first from bit i_len-1 down to bit 0; 1=dash, 0=dot.
- i_len  in  LEN_W  element count, 0..CODE_W; 0 = word space.
- i_valid  in  1  code/len valid.
- o_ready  out  1  keyer can accept; high only in IDLE.
- o_key  out  1  key on (active high; top inverts for the active-low LEDs).
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when a character's trailing gap ends.

Behaviour:
- Reset (asynchronous, rst=0): state IDLE; o_key=0, o_busy=0, o_done=0, o_ready=1; unit prescaler, element index and registered code/len cleared.
- Accept: i_valid && o_ready on a rising edge. Registers i_code, and i_len clamped to CODE_W if larger. Prescaler restarts at 0 and the element index is set to len-1.
- Latency: o_key first rises on the edge after acceptance. o_ready and o_busy change on that same edge.
- Unit tick: fires when prescaler == UNIT_CYCLES-1, then the prescaler wraps to 0. A phase length of N units = N*UNIT_CYCLES clocks exactly.
- IDLE: o_ready=1. On accept with len>0 go to ON; with len==0 go to WORD.
- ON: o_key=1 for 3 units if code[index]==1, else 1 unit. Then go to GAP.
- GAP: o_key=0 for 1 unit. If index==0 go to CHAR; else decrement index and go to ON.
- CHAR: o_key=0 for 2 extra units, giving a 3-unit total character gap. Then go to IDLE.
- WORD: o_key=0 for 4 units (previous character's 3 + 4 = 7). Then go to IDLE.
- o_done: pulses high on the edge leaving CHAR or WORD, coincident with entering IDLE.
- Back-to-back: if i_valid is held high, the next character is accepted on the first IDLE cycle. That costs one idle clock between characters; this is intentional.
- i_valid while busy: ignored, no side effects. Inputs are sampled only at accept.
- o_busy = !o_ready at all times.
- Reset mid-operation: o_key drops immediately (asynchronously). The in-flight character is discarded and o_done is not pulsed.
- Arithmetic:
  - Prescaler width is clog2(UNIT_CYCLES).
  - Phase unit counter is 3 bits wide (enough for 4 units), or wider under the macro so it holds the stretched maximum.
  - Index is LEN_W bits and never underflows; the index==0 check precedes any decrement.

Optional Feature:
- Macro MORSE_FARNSWORTH_EN.
- Defined: CHAR extra duration = 2*GAP_MULT units and WORD duration = 4*GAP_MULT units. Element timing (dot, dash, 1-unit element gap) is unchanged.
- Undefined: durations exactly as in Behaviour; GAP_MULT is ignored.

Test Plan (UNIT_CYCLES=4):
- 'E' (code=8'h00, len=1): o_key high 4 clocks, then low 12 clocks. o_done pulses on the clock after those 12; o_ready returns to 1 on that same clock.
- 'A' (code=8'b01, len=2) -> key pattern:
  - o_key high 4, low 4, high 12, low 12 clocks.
  - o_done pulses once.
  - o_ready low throughout the character.
- Space (len=0) -> o_key stays 0 for 16 clocks, then o_done pulses; o_busy is 1 for exactly 16 clocks.
- Assert rst=0 during the dash of 'T' (code=8'h01, len=1) -> o_key=0 with no clock edge, and no o_done. After release, o_ready=1, and a new 'E' times correctly from its accept.
- Hold i_valid=1 presenting 'E', then change the inputs to 'T' while busy:
  - Only 'E' is keyed until IDLE.
  - 'T' is accepted on the first IDLE clock.
  - o_key is high 12 clocks for 'T'.
  - len=9 is clamped to 8 elements.
- MORSE_FARNSWORTH_EN with GAP_MULT=2, 'E' -> o_key high 4 clocks, low 4+16=20 clocks. Space -> key low 32 clocks.
